locker_retrieval_controller: RTL and testbench

- Pickup side of the delivery locker system; complements the deposit/assignment logic.
- Holds a per-locker pickup-code table, loaded by deposit records.
- Takes keypad digits serially, authenticates the entered code against occupied lockers and opens the matching door.
- After the door is opened and shut, hands the locker back to the assignment logic through a valid/ready release handshake. Repeated wrong codes trigger a lockout.

---
 rtl/locker_retrieval_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_locker_retrieval_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/locker_retrieval_controller.sv
// Pickup side of the delivery locker: holds per-locker pickup codes, authenticates
// serially keyed codes, drives the door strike and hands emptied lockers back for reassignment.
module locker_retrieval_controller #(
    parameter int NUM_LOCKERS    = 8,
    parameter int ID_W           = 3,
    parameter int CODE_DIGITS    = 4,
    parameter int OPEN_CYCLES    = 1000,
    parameter int ENTRY_TIMEOUT  = 5000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 10000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dep_valid,
    input  logic [ID_W-1:0]          dep_locker,
    input  logic [4*CODE_DIGITS-1:0] dep_code,
    output logic                     dep_ready,
    output logic                     dep_err,
    input  logic                     key_valid,
    input  logic [3:0]               key_digit,
    input  logic [NUM_LOCKERS-1:0]   door_closed,
    output logic [NUM_LOCKERS-1:0]   door_open,
    output logic                     rel_valid,
    output logic [ID_W-1:0]          rel_locker,
    input  logic                     rel_ready,
    output logic [NUM_LOCKERS-1:0]   occupied,
    output logic                     auth_ok_led,
    output logic                     auth_fail_led,
    output logic                     locked_out
);

    localparam int CODE_W = 4 * CODE_DIGITS;
    localparam int TMAX   = (OPEN_CYCLES > ENTRY_TIMEOUT)
                          ? ((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES)
                          : ((ENTRY_TIMEOUT > LOCKOUT_CYCLES) ? ENTRY_TIMEOUT : LOCKOUT_CYCLES);
    localparam int TMR_W  = $clog2(TMAX + 1);
    localparam int CNT_W  = $clog2(CODE_DIGITS + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ENTRY     = 3'd1;
    localparam logic [2:0] S_SEARCH    = 3'd2;
    localparam logic [2:0] S_OPEN      = 3'd3;
    localparam logic [2:0] S_WAITCLOSE = 3'd4;
    localparam logic [2:0] S_RELEASE   = 3'd5;
    localparam logic [2:0] S_FAIL      = 3'd6;
    localparam logic [2:0] S_LOCKOUT   = 3'd7;

    logic [2:0]             state_q, state_d;
    logic [CODE_W-1:0]      code_in_q, code_in_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [FAIL_W-1:0]      fail_q, fail_d;
    logic [ID_W-1:0]        sel_q, sel_d;
    logic                   opened_q, opened_d;
    logic                   dep_err_q;
    logic [NUM_LOCKERS-1:0] occ_q;
    logic [CODE_W-1:0]      code_q [NUM_LOCKERS];

    logic [NUM_LOCKERS-1:0] match;
    logic                   hit;
    logic [ID_W-1:0]        hit_idx;
    logic                   held_busy;
    logic                   dep_reject;
    logic                   dep_accept;
    logic                   rel_fire;
    logic                   opened_now;
    logic                   key_is_digit;

    // Every occupied entry is compared against the entered code at once.
    for (genvar gi = 0; gi < NUM_LOCKERS; gi++) begin : g_lockers
        assign match[gi]     = occ_q[gi] && (code_q[gi] == code_in_q);
        assign door_open[gi] = (state_q == S_OPEN) && (sel_q == ID_W'(gi));
    end

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_LOCKERS - 1; i >= 0; i--) begin
            if (match[i]) hit_idx = ID_W'(i);
        end
    end
    assign hit = |match;

    // The locker being opened or released must not be re-deposited under us.
    assign held_busy  = ((state_q == S_OPEN) || (state_q == S_WAITCLOSE) || (state_q == S_RELEASE))
                        && (dep_locker == sel_q);
    assign dep_reject = dep_valid && (occ_q[dep_locker] || held_busy);
    assign dep_accept = dep_valid && !dep_reject;
    assign rel_fire   = (state_q == S_RELEASE) && rel_ready;
    assign opened_now = opened_q || !door_closed[sel_q];
    assign key_is_digit = (key_digit <= 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
            for (int i = 0; i < NUM_LOCKERS; i++) code_q[i] <= '0;
            dep_err_q <= 1'b0;
        end else begin
            dep_err_q <= dep_reject;
            if (dep_accept) begin
                occ_q[dep_locker]  <= 1'b1;
                code_q[dep_locker] <= dep_code;
            end
            if (rel_fire) occ_q[sel_q] <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_in_d = code_in_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        fail_d    = fail_q;
        sel_d     = sel_q;
        opened_d  = opened_q;
        case (state_q)
            S_IDLE: begin
                if (key_valid && key_is_digit) begin
                    code_in_d = CODE_W'(key_digit);
                    cnt_d     = CNT_W'(1);
                    tmr_d     = '0;
                    state_d   = (CODE_DIGITS == 1) ? S_SEARCH : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (key_valid) begin
                    tmr_d = '0;
                    if (!key_is_digit) begin
                        code_in_d = '0;
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                    end else begin
                        code_in_d = (code_in_q << 4) | CODE_W'(key_digit);
                        cnt_d     = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(CODE_DIGITS - 1)) state_d = S_SEARCH;
                    end
                end else if (tmr_q == TMR_W'(ENTRY_TIMEOUT - 1)) begin
                    code_in_d = '0;
                    cnt_d     = '0;
                    tmr_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_SEARCH: begin
                cnt_d = '0;
                if (hit) begin
                    sel_d    = hit_idx;
                    fail_d   = '0;
                    tmr_d    = '0;
                    opened_d = 1'b0;
                    state_d  = S_OPEN;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                fail_d = (fail_q == FAIL_W'(MAX_FAILS)) ? fail_q : fail_q + FAIL_W'(1);
                tmr_d  = '0;
                state_d = (fail_q == FAIL_W'(MAX_FAILS - 1)) ? S_LOCKOUT : S_IDLE;
            end
            S_LOCKOUT: begin
                if (tmr_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                    tmr_d   = '0;
                    fail_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_OPEN: begin
                opened_d = opened_now;
                if (tmr_q == TMR_W'(OPEN_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = opened_now ? S_WAITCLOSE : S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAITCLOSE: begin
                if (door_closed[sel_q]) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (rel_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            code_in_q <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            fail_q    <= '0;
            sel_q     <= '0;
            opened_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_in_q <= code_in_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            fail_q    <= fail_d;
            sel_q     <= sel_d;
            opened_q  <= opened_d;
        end
    end

    assign dep_ready     = !reset;
    assign dep_err       = dep_err_q;
    assign occupied      = occ_q;
    assign auth_ok_led   = (state_q == S_OPEN);
    assign auth_fail_led = (state_q == S_FAIL);
    assign locked_out    = (state_q == S_LOCKOUT);
    assign rel_valid     = (state_q == S_RELEASE);
    assign rel_locker    = (state_q == S_RELEASE) ? sel_q : '0;

endmodule

// File: tb/tb_locker_retrieval_controller.sv
// Directed scenarios for the locker pickup controller; expected events are queued by the
// stimulus and consumed by an independent monitor as the DUT produces them.
module tb_locker_retrieval_controller;

    localparam int NL = 8;
    localparam int IW = 3;

    localparam logic [3:0] EV_DOOR    = 4'd1;
    localparam logic [3:0] EV_DOORLEN = 4'd2;
    localparam logic [3:0] EV_FAIL    = 4'd3;
    localparam logic [3:0] EV_LOCK    = 4'd4;
    localparam logic [3:0] EV_LOCKLEN = 4'd5;
    localparam logic [3:0] EV_DEPERR  = 4'd6;
    localparam logic [3:0] EV_REL     = 4'd7;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          dep_valid;
    logic [IW-1:0] dep_locker;
    logic [15:0]   dep_code;
    logic          dep_ready;
    logic          dep_err;
    logic          key_valid;
    logic [3:0]    key_digit;
    logic [NL-1:0] door_closed;
    logic [NL-1:0] door_open;
    logic          rel_valid;
    logic [IW-1:0] rel_locker;
    logic          rel_ready;
    logic [NL-1:0] occupied;
    logic          auth_ok_led;
    logic          auth_fail_led;
    logic          locked_out;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    locker_retrieval_controller dut (
        .clk          (clk),
        .reset        (reset),
        .dep_valid    (dep_valid),
        .dep_locker   (dep_locker),
        .dep_code     (dep_code),
        .dep_ready    (dep_ready),
        .dep_err      (dep_err),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .door_closed  (door_closed),
        .door_open    (door_open),
        .rel_valid    (rel_valid),
        .rel_locker   (rel_locker),
        .rel_ready    (rel_ready),
        .occupied     (occupied),
        .auth_ok_led  (auth_ok_led),
        .auth_fail_led(auth_fail_led),
        .locked_out   (locked_out)
    );

    always #5 clk = ~clk;

    function automatic void expect_ev(input logic [3:0] kind, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor side of the scoreboard.
    task automatic got(input logic [3:0] kind, input logic [15:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d data=%0h required=none", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.data !== data) begin
                errors++;
                $display("FAIL event kind=%0d data=%0h required kind=%0d data=%0h",
                         kind, data, e.kind, e.data);
            end else begin
                $display("t=%0t event kind=%0d data=%0h ok", $time, kind, data);
            end
        end
    endtask

    initial begin : monitor
        logic [NL-1:0] prev_door;
        logic          prev_lock;
        int            door_len;
        int            lock_len;
        prev_door = '0;
        prev_lock = 1'b0;
        door_len  = 0;
        lock_len  = 0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_door = '0;
                prev_lock = 1'b0;
                door_len  = 0;
                lock_len  = 0;
            end else begin
                if (door_open != '0 && prev_door == '0) got(EV_DOOR, 16'(door_open));
                if (door_open != '0) door_len++;
                if (door_open == '0 && prev_door != '0) begin
                    got(EV_DOORLEN, 16'(door_len));
                    door_len = 0;
                end
                if (locked_out && !prev_lock) got(EV_LOCK, 16'h0);
                if (locked_out) lock_len++;
                if (!locked_out && prev_lock) begin
                    got(EV_LOCKLEN, 16'(lock_len));
                    lock_len = 0;
                end
                if (auth_fail_led) got(EV_FAIL, 16'h0);
                if (dep_err) got(EV_DEPERR, 16'h0);
                if (rel_valid && rel_ready) got(EV_REL, 16'(rel_locker));
                prev_door = door_open;
                prev_lock = locked_out;
            end
        end
    end

    function automatic logic probe(input int which);
        case (which)
            0:       return |door_open;
            1:       return rel_valid;
            default: return locked_out;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (probe(which) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(probe(which)), 32'(lvl));
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) press(code[4*i +: 4]);
    endtask

    task automatic deposit(input logic [IW-1:0] l, input logic [15:0] c, input bit err);
        if (err) expect_ev(EV_DEPERR, 16'h0);
        dep_valid  = 1'b1;
        dep_locker = l;
        dep_code   = c;
        @(negedge clk);
        dep_valid  = 1'b0;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset       = 1'b1;
        dep_valid   = 1'b0;
        dep_locker  = '0;
        dep_code    = '0;
        key_valid   = 1'b0;
        key_digit   = '0;
        door_closed = '1;
        rel_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {10'h0, door_open, occupied, rel_valid, auth_ok_led,
                              auth_fail_led, locked_out, dep_err, dep_ready}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("dep_ready", 32'(dep_ready), 32'h1);

        // Basic deposit, pickup, door cycle and release.
        deposit(3'd5, 16'h2468, 1'b0);
        chk("occ_after_dep5", 32'(occupied), 32'h20);
        expect_ev(EV_DOOR, 16'h20);
        expect_ev(EV_DOORLEN, 16'd1000);
        expect_ev(EV_REL, 16'd5);
        press(4'd2); press(4'd4); press(4'd6);
        key_valid = 1'b1;
        key_digit = 4'd8;
        @(negedge clk);
        key_valid = 1'b0;
        chk("door_in_search", 32'(door_open), 32'h0);
        @(negedge clk);
        chk("door_two_after_key", 32'(door_open), 32'h20);
        chk("auth_ok_led", 32'(auth_ok_led), 32'h1);
        repeat (5) @(negedge clk);
        door_closed[5] = 1'b0;
        repeat (3) @(negedge clk);
        door_closed[5] = 1'b1;
        wait_for(1, 1'b1, 1100, "rel_valid_rise");
        chk("rel_locker", 32'(rel_locker), 32'd5);
        repeat (3) @(negedge clk);
        chk("rel_valid_held", {31'h0, rel_valid}, 32'h1);
        rel_ready = 1'b1;
        @(negedge clk);
        rel_ready = 1'b0;
        chk("rel_valid_drop", 32'(rel_valid), 32'h0);
        chk("occ_after_release", 32'(occupied), 32'h0);

        // Three wrong codes lead to lockout; keys inside lockout are ignored.
        deposit(3'd5, 16'h2468, 1'b0);
        for (int i = 0; i < 3; i++) expect_ev(EV_FAIL, 16'h0);
        expect_ev(EV_LOCK, 16'h0);
        expect_ev(EV_LOCKLEN, 16'd10000);
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h1111);
            if (i < 2) repeat (3) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("locked_out_high", 32'(locked_out), 32'h1);
        enter_code(16'h2468);
        wait_for(2, 1'b0, 10100, "lockout_end");
        @(negedge clk);

        // Correct code, door never opened: no release, locker stays occupied.
        expect_ev(EV_DOOR, 16'h20);
        expect_ev(EV_DOORLEN, 16'd1000);
        enter_code(16'h2468);
        wait_for(0, 1'b1, 10, "door_up_unopened");
        wait_for(0, 1'b0, 1100, "door_down_unopened");
        repeat (3) @(negedge clk);
        chk("occ_kept", 32'(occupied), 32'h20);
        chk("no_rel_valid", 32'(rel_valid), 32'h0);
        expect_ev(EV_DOOR, 16'h20);
        expect_ev(EV_DOORLEN, 16'd1000);
        expect_ev(EV_REL, 16'd5);
        enter_code(16'h2468);
        wait_for(0, 1'b1, 10, "door_up_reentry");
        door_closed[5] = 1'b0;
        @(negedge clk);
        door_closed[5] = 1'b1;
        wait_for(1, 1'b1, 1100, "rel_valid_reentry");
        rel_ready = 1'b1;
        @(negedge clk);
        rel_ready = 1'b0;
        chk("occ_after_release2", 32'(occupied), 32'h0);

        // Duplicate deposit rejected; deposit during SEARCH is not visible to it.
        deposit(3'd5, 16'h2468, 1'b0);
        deposit(3'd5, 16'h9999, 1'b1);
        @(negedge clk);
        chk("occ_after_dup", 32'(occupied), 32'h20);
        expect_ev(EV_FAIL, 16'h0);
        press(4'd1); press(4'd1); press(4'd1);
        key_valid = 1'b1;
        key_digit = 4'd1;
        @(negedge clk);
        key_valid  = 1'b0;
        dep_valid  = 1'b1;
        dep_locker = 3'd2;
        dep_code   = 16'h1111;
        @(negedge clk);
        dep_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("occ_after_dep2", 32'(occupied), 32'h24);
        expect_ev(EV_DOOR, 16'h04);
        expect_ev(EV_DOORLEN, 16'd1000);
        enter_code(16'h1111);
        wait_for(0, 1'b1, 10, "door_up_l2");
        wait_for(0, 1'b0, 1100, "door_down_l2");
        repeat (2) @(negedge clk);

        // Entry timeout and CLEAR discard digits without counting a failure.
        press(4'd2); press(4'd4);
        repeat (5010) @(negedge clk);
        press(4'd6); press(4'd8);
        repeat (5) @(negedge clk);
        chk("timeout_discards", 32'(door_open), 32'h0);
        press(4'hB);
        press(4'd2); press(4'd4); press(4'hB);
        press(4'd6); press(4'd8);
        repeat (5) @(negedge clk);
        chk("clear_discards", 32'(door_open), 32'h0);
        press(4'hF);
        expect_ev(EV_FAIL, 16'h0);
        expect_ev(EV_FAIL, 16'h0);
        for (int i = 0; i < 2; i++) begin
            enter_code(16'h3333);
            repeat (3) @(negedge clk);
        end
        chk("no_lockout_two_fails", 32'(locked_out), 32'h0);
        expect_ev(EV_DOOR, 16'h20);
        expect_ev(EV_DOORLEN, 16'd1000);
        enter_code(16'h2468);
        wait_for(0, 1'b1, 10, "door_up_l5");
        wait_for(0, 1'b0, 1100, "door_down_l5");
        repeat (2) @(negedge clk);
        expect_ev(EV_FAIL, 16'h0);
        enter_code(16'h3333);
        repeat (5) @(negedge clk);
        chk("success_cleared_fails", 32'(locked_out), 32'h0);

        // Asynchronous reset in the middle of OPEN.
        expect_ev(EV_DOOR, 16'h20);
        enter_code(16'h2468);
        wait_for(0, 1'b1, 10, "door_up_rst");
        repeat (10) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_door_open", 32'(door_open), 32'h0);
        chk("rst_state_outs", {21'h0, occupied, rel_valid, auth_ok_led, auth_fail_led},
            32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        chk("events_outstanding", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
